// File: rtl/bagging_feeder.sv
// bagging_feeder: buffers one feature sample, runs it through NUM_MODELS
// weak learners on the shared serial classifier and emits the majority vote.
// Optional watchdog on the classifier wait: define BAGGING_FEEDER_TIMEOUT_EN.
module bagging_feeder #(
    parameter int NUM_MODELS = 5,
    parameter int NUM_TAPS   = 30,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w_we,
    input  logic [3:0] w_model,
    input  logic [4:0] w_addr,
    input  logic [8:0] w_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [1:0] s_data,
    output logic       clf_clr_n,
    output logic       clf_en,
    output logic [1:0] clf_data,
    output logic [8:0] clf_weight,
    output logic [8:0] clf_bias,
    input  logic [1:0] clf_result,
    input  logic       clf_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_result,
    output logic       out_err
);
    localparam int         VW     = $clog2(NUM_MODELS + 1) + 1;
    localparam logic [3:0] LAST_M = 4'(NUM_MODELS - 1);
    localparam logic [4:0] LAST_T = 5'(NUM_TAPS - 1);
    localparam logic [4:0] BIAS_A = 5'(NUM_TAPS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_START,
        S_STREAM, S_WAIT, S_VOTE, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           tap_q, tap_d;
    logic [3:0]           model_q, model_d;
    logic signed [VW-1:0] vote_q, vote_d;
    logic                 rdy_q;
    logic [1:0]           res_q;
    logic                 s_ready_q;
    logic                 clr_n_q;
    logic [8:0]           coef_q [16][32];
    logic [1:0]           feat_q [32];
    logic [8:0]           bias_w;
    logic                 accept;

`ifdef BAGGING_FEEDER_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
`endif

    assign accept    = s_valid & s_ready_q;
    assign s_ready   = s_ready_q;
    assign clf_clr_n = clr_n_q;
    assign bias_w    = coef_q[model_q][BIAS_A];

    // Coefficient and feature storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we && state_q == S_IDLE &&
            w_model <= LAST_M && w_addr <= BIAS_A)
            coef_q[w_model][w_addr] <= w_data;
        if (accept)
            feat_q[tap_q] <= s_data;
    end

    // State, counters and registered handshake/clear outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            model_q   <= '0;
            vote_q    <= '0;
            rdy_q     <= 1'b0;
            res_q     <= 2'b00;
            s_ready_q <= 1'b0;
            clr_n_q   <= 1'b0;
`ifdef BAGGING_FEEDER_TIMEOUT_EN
            wcnt_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            model_q   <= model_d;
            vote_q    <= vote_d;
            rdy_q     <= clf_ready;
            res_q     <= clf_result;
            s_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
            clr_n_q   <= (state_d != S_CLR);
`ifdef BAGGING_FEEDER_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Sequencing of load, per-model run, vote and result handshake.
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        model_d    = model_q;
        vote_d     = vote_q;
        clf_en     = 1'b0;
        clf_data   = 2'b00;
        clf_weight = 9'd0;
        clf_bias   = 9'd0;
        out_valid  = 1'b0;
        out_result = 2'b00;
        out_err    = 1'b0;
`ifdef BAGGING_FEEDER_TIMEOUT_EN
        wcnt_d     = wcnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tap_d   = 5'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (tap_q == LAST_T) begin
                        tap_d   = '0;
                        model_d = '0;
                        vote_d  = '0;
`ifdef BAGGING_FEEDER_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                        state_d = S_CLR;
                    end else begin
                        tap_d = tap_q + 5'd1;
                    end
                end
            end
            S_CLR: state_d = S_START;
            S_START: begin
                clf_en   = 1'b1;
                clf_bias = bias_w;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                clf_data   = feat_q[tap_q];
                clf_weight = coef_q[model_q][tap_q];
                clf_bias   = bias_w;
                if (tap_q == LAST_T) begin
                    tap_d   = '0;
`ifdef BAGGING_FEEDER_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                    state_d = S_WAIT;
                end else begin
                    tap_d = tap_q + 5'd1;
                end
            end
            S_WAIT: begin
                clf_bias = bias_w;
                if (rdy_q) begin
                    state_d = S_VOTE;
                end
`ifdef BAGGING_FEEDER_TIMEOUT_EN
                else if (wcnt_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
`endif
            end
            S_VOTE: begin
                clf_bias = bias_w;
                if (res_q == 2'b11) vote_d = vote_q - 1'b1;
                else                vote_d = vote_q + 1'b1;
                if (model_q == LAST_M) begin
                    state_d = S_DONE;
                end else begin
                    model_d = model_q + 4'd1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                out_valid  = 1'b1;
                out_result = vote_q[VW-1] ? 2'b11 : 2'b01;
`ifdef BAGGING_FEEDER_TIMEOUT_EN
                out_err = err_q;
                if (err_q) out_result = 2'b01;
`endif
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
